// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mmio_uart_tx #(
   parameter int DATA_WIDTH = 32,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sel,
   input  logic                  w_en,
   input  logic [3:0]            addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  tx,
   output logic                  tx_busy
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BCW = $clog2(DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [BCW-1:0]  baud_cnt_q, baud_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            baud_done, pop;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_q;
   logic            overflow_q, enable_q;
   logic            full, empty;
   logic            bus_wr, push_req, push, status_wr, ctrl_wr;
   logic            unused_bits;

   assign bus_wr    = sel & w_en;
   assign push_req  = bus_wr && (addr[3:2] == 2'd0);
   assign status_wr = bus_wr && (addr[3:2] == 2'd1);
   assign ctrl_wr   = bus_wr && (addr[3:2] == 2'd2);
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   // full is the pre-pop value, so a push into a full FIFO is dropped even when a pop shares the edge
   assign push      = push_req & ~full;
   assign baud_done = (baud_cnt_q == BCW'(DIV - 1));
   assign tx        = tx_q;
   assign tx_busy   = (state_q != IDLE);
   assign unused_bits = ^{w_data[DATA_WIDTH-1:8], addr[1:0]};

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_q && !empty) begin
               pop        = 1'b1;
               shift_d    = mem[rd_ptr];
               baud_cnt_d = '0;
               state_d    = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_cnt_d = '0;
               bit_idx_d  = 3'd0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         default: begin
            if (baud_done) begin
               baud_cnt_d = '0;
               if (enable_q && !empty) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // tx is registered from the next-state view so the line changes on the same edge as the state
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         enable_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_req && full) begin
            overflow_q <= 1'b1;
         end else if (status_wr && w_data[3]) begin
            overflow_q <= 1'b0;
         end
         if (ctrl_wr) enable_q <= w_data[0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= w_data[7:0];
   end

   always_comb begin
      r_data = '0;
      if (sel) begin
         case (addr[3:2])
            2'd1: begin
               r_data[0]      = tx_busy;
               r_data[1]      = full;
               r_data[2]      = empty;
               r_data[3]      = overflow_q;
               r_data[8 +: CW] = count_q;
            end
            2'd2:    r_data[0] = enable_q;
            default: r_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        w_en = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [31:0] w_data = 32'h0;
   logic [31:0] r_data;
   logic        tx;
   logic        tx_busy;
   logic [31:0] rd;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          lows;

   mmio_uart_tx #(
      .DATA_WIDTH(32),
      .CLK_FREQ  (1000),
      .BAUD      (100),
      .FIFO_DEPTH(8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sel    (sel),
      .w_en   (w_en),
      .addr   (addr),
      .w_data (w_data),
      .r_data (r_data),
      .tx     (tx),
      .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      sel = 1'b1; w_en = 1'b1; addr = a; w_data = d;
      @(posedge clk);
      #1;
      sel = 1'b0; w_en = 1'b0; w_data = 32'h0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      sel = 1'b1; w_en = 1'b0; addr = a;
      #1;
      d = r_data;
      sel = 1'b0;
   endtask

   // call right after the edge that loaded START; checks all 100 clocks of the frame
   task automatic expect_frame(input logic [7:0] b, input string tag);
      logic e;
      int   bn;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         bn = k / 10;
         if (bn == 0)      e = 1'b0;
         else if (bn == 9) e = 1'b1;
         else              e = b[bn-1];
         check($sformatf("%s_k%0d", tag, k), {31'b0, tx}, {31'b0, e});
      end
   endtask

   task automatic count_lows(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (tx !== 1'b1) n++;
      end
   endtask

   initial begin
      // 1: reset state and register map
      repeat (3) @(negedge clk);
      check("rst_tx_in_reset", {31'b0, tx}, 32'h1);
      reset = 1'b0;
      @(negedge clk);
      check("s1_tx", {31'b0, tx}, 32'h1);
      check("s1_busy", {31'b0, tx_busy}, 32'h0);
      bus_read(4'h4, rd); check("s1_status", rd, 32'h4);
      bus_read(4'h8, rd); check("s1_ctrl", rd, 32'h1);
      bus_read(4'hC, rd); check("s1_rsvd", rd, 32'h0);
      bus_read(4'h0, rd); check("s1_txdata_rd", rd, 32'h0);
      addr = 4'h4; sel = 1'b0; #1;
      check("s1_unselected", r_data, 32'h0);
      @(negedge clk);
      bus_write(4'hC, 32'hFFFF_FFFF);
      bus_read(4'hC, rd); check("s1_rsvd_after_wr", rd, 32'h0);
      bus_read(4'h4, rd); check("s1_status_after_rsvd", rd, 32'h4);
      bus_read(4'h8, rd); check("s1_ctrl_after_rsvd", rd, 32'h1);

      // 2: single frame 0xA5
      @(negedge clk);
      bus_write(4'h0, 32'hA5);
      @(negedge clk);
      check("s2_latency_tx", {31'b0, tx}, 32'h1);
      @(posedge clk);
      expect_frame(8'hA5, "s2");
      check("s2_busy_last_stop", {31'b0, tx_busy}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      check("s2_busy_done", {31'b0, tx_busy}, 32'h0);
      bus_read(4'h4, rd); check("s2_status", rd, 32'h4);

      // 3: ten back-to-back writes, overflow on the tenth
      @(negedge clk);
      fork
         begin
            for (int i = 1; i <= 10; i++) begin
               bus_write(4'h0, i);
               if (i == 9) begin
                  bus_read(4'h4, rd); check("s3_status_full", rd, 32'h803);
               end
            end
            bus_read(4'h4, rd); check("s3_status_ovf", rd, 32'h80B);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            for (int b = 1; b <= 9; b++) expect_frame(b[7:0], $sformatf("s3_b%0d", b));
         end
      join
      @(posedge clk);
      count_lows(25, lows);
      check("s3_no_tenth_frame", lows, 32'h0);
      bus_read(4'h4, rd); check("s3_status_end", rd, 32'hC);

      // 6: overflow clear is write-1-to-clear on bit 3 only
      @(negedge clk);
      bus_write(4'h4, 32'hFFFF_FFF7);
      bus_read(4'h4, rd); check("s6_status_keep", rd, 32'hC);
      bus_write(4'h4, 32'h8);
      bus_read(4'h4, rd); check("s6_status_clr", rd, 32'h4);

      // 4: enable gating
      @(negedge clk);
      bus_write(4'h8, 32'h0);
      bus_read(4'h8, rd); check("s4_ctrl_off", rd, 32'h0);
      bus_write(4'h0, 32'h55);
      count_lows(30, lows);
      check("s4_held_idle", lows, 32'h0);
      check("s4_busy_off", {31'b0, tx_busy}, 32'h0);
      bus_read(4'h4, rd); check("s4_status_queued", rd, 32'h100);
      @(negedge clk);
      bus_write(4'h8, 32'h1);
      @(negedge clk);
      check("s4_enable_edge_tx", {31'b0, tx}, 32'h1);
      @(posedge clk);
      expect_frame(8'h55, "s4");
      @(posedge clk);
      @(negedge clk);
      check("s4_busy_done", {31'b0, tx_busy}, 32'h0);

      // 5: asynchronous reset mid-frame
      @(negedge clk);
      bus_write(4'h0, 32'h00);
      bus_write(4'h0, 32'h33);
      repeat (45) @(negedge clk);
      check("s5_bit3_low", {31'b0, tx}, 32'h0);
      check("s5_busy_mid", {31'b0, tx_busy}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("s5_tx_async", {31'b0, tx}, 32'h1);
      check("s5_busy_async", {31'b0, tx_busy}, 32'h0);
      bus_read(4'h4, rd); check("s5_status_rst", rd, 32'h4);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      count_lows(120, lows);
      check("s5_no_residual", lows, 32'h0);
      bus_read(4'h4, rd); check("s5_status_after", rd, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
